// File: rtl/sparse_coo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sparse_coo_pkg
// Brief    : Shared types and FP8 E4M3 / fixed-point constants for the COO SpMM.
// Revision : 1.0
// ============================================================================
package sparse_coo_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam int EXP_W    = 4;
    localparam int MAN_W    = 3;
    localparam int FP8_W    = 1 + EXP_W + MAN_W;
    localparam int EXP_BIAS = 7;
    localparam int FRAC     = 18;
    // Product of two E4M3 values in FRAC fixed point is (siga*sigb) << (ea+eb-SHIFT_OFS)
    localparam int SHIFT_OFS = 2 * (EXP_BIAS + MAN_W) - FRAC;

    // Coordinate field wide enough for any supported N (N <= 256)
    localparam int IDX_W = 8;

    typedef struct packed {
        logic [FP8_W-1:0] data;
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } coo_entry_t;

endpackage
`default_nettype wire

// File: rtl/fp8_e4m3_mul_fx.sv
`default_nettype none
// ============================================================================
// Module   : fp8_e4m3_mul_fx
// Brief    : Exact combinational E4M3 x E4M3 multiply into signed fixed point.
// Revision : 1.0
// ============================================================================
module fp8_e4m3_mul_fx
    import sparse_coo_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic [FP8_W-1:0] i_a,
    input  logic [FP8_W-1:0] i_b,
    output logic [ACC_W-1:0] o_prod,
    output logic             o_nan
);

    logic [EXP_W-1:0]   w_ea;
    logic [EXP_W-1:0]   w_eb;
    logic [MAN_W:0]     w_siga;
    logic [MAN_W:0]     w_sigb;
    logic [2*MAN_W+1:0] w_sig;
    logic [EXP_W:0]     w_shift;
    logic [ACC_W-1:0]   w_mag;
    logic               w_neg;

    always_comb begin
        // Subnormals use exponent 1 without the hidden bit
        w_ea    = (i_a[MAN_W +: EXP_W] == '0) ? EXP_W'(1) : i_a[MAN_W +: EXP_W];
        w_eb    = (i_b[MAN_W +: EXP_W] == '0) ? EXP_W'(1) : i_b[MAN_W +: EXP_W];
        w_siga  = {(i_a[MAN_W +: EXP_W] != '0), i_a[MAN_W-1:0]};
        w_sigb  = {(i_b[MAN_W +: EXP_W] != '0), i_b[MAN_W-1:0]};
        w_sig   = (2*MAN_W+2)'(w_siga) * (2*MAN_W+2)'(w_sigb);
        w_shift = (EXP_W+1)'(w_ea) + (EXP_W+1)'(w_eb) - (EXP_W+1)'(SHIFT_OFS);
        w_mag   = ACC_W'(w_sig) << w_shift;
        w_neg   = i_a[FP8_W-1] ^ i_b[FP8_W-1];
        o_nan   = (i_a[FP8_W-2:0] == '1) || (i_b[FP8_W-2:0] == '1);
        o_prod  = o_nan ? '0 : (w_neg ? (~w_mag + ACC_W'(1)) : w_mag);
    end

endmodule
`default_nettype wire

// File: rtl/sparse_coo_spmm_stream.sv
`default_nettype none
// ============================================================================
// Module   : sparse_coo_spmm_stream
// Brief    : Loads two COO FP8 operands, accumulates A*B into N*N cells, drains C.
// Revision : 1.0
// ============================================================================
module sparse_coo_spmm_stream
    import sparse_coo_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 32,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [FP8_W-1:0]        a_data,
    input  logic [$clog2(N)-1:0]    a_row,
    input  logic [$clog2(N)-1:0]    a_col,
    input  logic                    a_last,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [FP8_W-1:0]        b_data,
    input  logic [$clog2(N)-1:0]    b_row,
    input  logic [$clog2(N)-1:0]    b_col,
    input  logic                    b_last,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [$clog2(N)-1:0]    c_row,
    output logic [$clog2(N)-1:0]    c_col,
    output logic signed [ACC_W-1:0] c_data,
    output logic                    c_last,
    output logic                    busy,
    output logic                    ovf_flag,
    output logic                    nan_flag
);

    localparam int RW = $clog2(N);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH * DEPTH + 2) + 1;

    state_t r_state, w_next;

    logic [CW-1:0]  r_na, r_nb;
    logic           r_a_done, r_b_done, r_started;
    logic           r_ovf, r_nan;
    logic [PW-1:0]  r_cyc;
    logic [IW-1:0]  r_i, r_j;
    logic           r_p_valid;
    logic [2*RW-1:0] r_p_idx;
    logic signed [ACC_W-1:0] r_p_prod;
    logic           r_c_valid, r_c_last;
    logic [RW-1:0]  r_c_row, r_c_col;
    logic signed [ACC_W-1:0] r_c_data;

    coo_entry_t              r_amem [DEPTH];
    coo_entry_t              r_bmem [DEPTH];
    logic signed [ACC_W-1:0] r_acc  [N*N];

    logic            w_a_fire, w_b_fire, w_first, w_drop;
    logic            w_start, w_to_drain, w_job_done, w_issue, w_hit, w_nan;
    logic [PW-1:0]   w_pairs;
    logic [2*RW-1:0] w_nidx;
    logic [ACC_W-1:0] w_prod;

    assign a_ready    = (r_state == ST_LOAD) && !r_a_done;
    assign b_ready    = (r_state == ST_LOAD) && !r_b_done;
    assign w_a_fire   = a_valid && a_ready;
    assign w_b_fire   = b_valid && b_ready;
    assign w_first    = (w_a_fire || w_b_fire) && !r_started;
    assign w_drop     = (w_a_fire && (r_na == CW'(DEPTH))) || (w_b_fire && (r_nb == CW'(DEPTH)));
    assign w_pairs    = PW'(r_na) * PW'(r_nb);
    assign w_issue    = (r_state == ST_COMPUTE) && (r_cyc < w_pairs);
    assign w_hit      = r_amem[r_i].col == r_bmem[r_j].row;
    assign w_start    = (r_state == ST_LOAD) && (w_next == ST_COMPUTE);
    assign w_to_drain = (r_state == ST_COMPUTE) && (w_next == ST_DRAIN);
    assign w_job_done = r_c_valid && c_ready && r_c_last;
    assign w_nidx     = {r_c_row, r_c_col} + (2*RW)'(1);

    assign busy     = (r_state == ST_COMPUTE) || (r_state == ST_DRAIN);
    assign ovf_flag = r_ovf;
    assign nan_flag = r_nan;
    assign c_valid  = r_c_valid;
    assign c_last   = r_c_last;
    assign c_row    = r_c_row;
    assign c_col    = r_c_col;
    assign c_data   = r_c_data;

    fp8_e4m3_mul_fx #(.ACC_W(ACC_W)) u_mul (
        .i_a    (r_amem[r_i].data),
        .i_b    (r_bmem[r_j].data),
        .o_prod (w_prod),
        .o_nan  (w_nan)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_LOAD;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_LOAD:    if (r_a_done && r_b_done) w_next = ST_COMPUTE;
            // Two trailing cycles let the last product clear the multiply/accumulate pipe
            ST_COMPUTE: if (r_cyc == w_pairs + PW'(1)) w_next = ST_DRAIN;
            ST_DRAIN:   if (w_job_done) w_next = ST_LOAD;
            default:    w_next = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_na <= '0; r_nb <= '0;
            r_a_done <= 1'b0; r_b_done <= 1'b0; r_started <= 1'b0;
            r_ovf <= 1'b0; r_nan <= 1'b0;
            r_cyc <= '0; r_i <= '0; r_j <= '0;
            r_p_valid <= 1'b0; r_p_idx <= '0; r_p_prod <= '0;
        end else begin
            if (w_a_fire) begin
                if (r_na != CW'(DEPTH)) r_na <= r_na + CW'(1);
                if (a_last) r_a_done <= 1'b1;
            end
            if (w_b_fire) begin
                if (r_nb != CW'(DEPTH)) r_nb <= r_nb + CW'(1);
                if (b_last) r_b_done <= 1'b1;
            end
            if (w_a_fire || w_b_fire) r_started <= 1'b1;
            if (w_first) begin
                r_ovf <= 1'b0;
                r_nan <= 1'b0;
            end
            if (w_drop) r_ovf <= 1'b1;
            if (w_issue && w_nan) r_nan <= 1'b1;

            if (w_start) begin
                r_cyc <= '0; r_i <= '0; r_j <= '0;
            end else if (r_state == ST_COMPUTE) begin
                r_cyc <= r_cyc + PW'(1);
                if (w_issue) begin
                    if (CW'(r_j) + CW'(1) == r_nb) begin
                        r_j <= '0;
                        r_i <= r_i + IW'(1);
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
            end

            r_p_valid <= w_issue && w_hit;
            r_p_idx   <= {r_amem[r_i].row[RW-1:0], r_bmem[r_j].col[RW-1:0]};
            r_p_prod  <= w_prod;

            if (w_job_done) begin
                r_na <= '0; r_nb <= '0;
                r_a_done <= 1'b0; r_b_done <= 1'b0; r_started <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_a_fire && (r_na < CW'(DEPTH)))
            r_amem[r_na[IW-1:0]] <= '{data: a_data, row: IDX_W'(a_row), col: IDX_W'(a_col)};
        if (w_b_fire && (r_nb < CW'(DEPTH)))
            r_bmem[r_nb[IW-1:0]] <= '{data: b_data, row: IDX_W'(b_row), col: IDX_W'(b_col)};
    end

    // Single-cycle read-modify-write, so consecutive hits on one cell chain naturally
    always_ff @(posedge clk) begin
        if (w_start) begin
            for (int k = 0; k < N*N; k++) r_acc[k] <= '0;
        end else if (r_p_valid) begin
            r_acc[r_p_idx] <= r_acc[r_p_idx] + r_p_prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_valid <= 1'b0; r_c_last <= 1'b0;
            r_c_row <= '0; r_c_col <= '0; r_c_data <= '0;
        end else if (w_to_drain) begin
            r_c_valid <= 1'b1; r_c_last <= 1'b0;
            r_c_row <= '0; r_c_col <= '0; r_c_data <= r_acc[0];
        end else if (r_c_valid && c_ready) begin
            if (r_c_last) begin
                r_c_valid <= 1'b0;
                r_c_last  <= 1'b0;
            end else begin
                {r_c_row, r_c_col} <= w_nidx;
                r_c_data <= r_acc[w_nidx];
                r_c_last <= (w_nidx == '1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sparse_coo_spmm_stream.sv
`default_nettype none
// Bench for sparse_coo_spmm_stream: directed COO jobs checked against a value-level model
// of the sparse product, with literal pins on the model for hand-worked cases.
module tb_sparse_coo_spmm_stream;

    localparam int N     = 8;
    localparam int DEPTH = 32;
    localparam int ACC_W = 48;
    localparam int RW    = 3;
    localparam int NN    = N * N;
    localparam logic [63:0] MASK = 64'h0000_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic a_valid, a_ready, a_last, b_valid, b_ready, b_last;
    logic [7:0] a_data, b_data;
    logic [RW-1:0] a_row, a_col, b_row, b_col, c_row, c_col;
    logic c_valid, c_ready, c_last, busy, ovf_flag, nan_flag;
    logic signed [ACC_W-1:0] c_data;

    sparse_coo_spmm_stream #(.N(N), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_row(a_row), .a_col(a_col), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_row(b_row), .b_col(b_col), .b_last(b_last),
        .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_col(c_col), .c_data(c_data), .c_last(c_last),
        .busy(busy), .ovf_flag(ovf_flag), .nan_flag(nan_flag)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; int r; int c; } ent_t;
    ent_t qa[$];
    ent_t qb[$];

    longint exp_c [NN];
    bit     exp_nan, exp_ovf;
    int     exp_cyc;
    int     n_cmp = 0, n_bad = 0;
    int     rdy_mode = 0;
    bit     job_done = 1'b0, chk_clear = 1'b0;
    int     comp_cyc = 0, n_beats = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Real value of an E4M3 code scaled by 2^(FRAC+FRAC) / 2^FRAC, i.e. value * 2^18
    function automatic longint fx(input logic [7:0] d);
        int e;
        longint sig, v;
        e   = int'(d[6:3]);
        sig = longint'(d[2:0]);
        if (e == 0) e = 1;
        else sig = sig + 8;
        v = sig << (e + 8);
        return d[7] ? -v : v;
    endfunction

    function automatic bit is_nan(input logic [7:0] d);
        return d[6:0] == 7'h7F;
    endfunction

    task automatic build_model();
        int na, nb;
        na = (qa.size() > DEPTH) ? DEPTH : qa.size();
        nb = (qb.size() > DEPTH) ? DEPTH : qb.size();
        for (int k = 0; k < NN; k++) exp_c[k] = 0;
        exp_nan = 1'b0;
        exp_ovf = (qa.size() > DEPTH) || (qb.size() > DEPTH);
        for (int i = 0; i < na; i++)
            for (int j = 0; j < nb; j++) begin
                if (is_nan(qa[i].d) || is_nan(qb[j].d)) exp_nan = 1'b1;
                else if (qa[i].c == qb[j].r)
                    exp_c[qa[i].r * N + qb[j].c] += (fx(qa[i].d) * fx(qb[j].d)) >>> 18;
            end
        exp_cyc = na * nb + 2;
    endtask

    initial begin
        c_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) c_ready = 1'b1;
            else c_ready = ~c_ready;
        end
    end

    // Output checker: ordering, data, c_last and hold-while-stalled on every valid cycle
    int d_idx = 0;
    bit stall = 1'b0;
    logic [RW-1:0] p_row, p_col;
    logic [ACC_W-1:0] p_data;
    always @(negedge clk) begin
        if (rst) begin
            d_idx = 0;
            stall = 1'b0;
        end else begin
            if (busy && !c_valid) comp_cyc++;
            if (c_valid) begin
                if (stall) begin
                    chk("hold_row", 64'(c_row), 64'(p_row));
                    chk("hold_col", 64'(c_col), 64'(p_col));
                    chk("hold_data", 64'(c_data) & MASK, 64'(p_data));
                end
                chk("c_index", 64'({c_row, c_col}), 64'(d_idx));
                chk("c_data", {16'b0, c_data}, exp_c[d_idx] & MASK);
                chk("c_last", 64'(c_last), 64'(d_idx == NN - 1));
                p_row = c_row; p_col = c_col; p_data = c_data;
                if (c_ready) begin
                    n_beats++;
                    stall = 1'b0;
                    if (d_idx == NN - 1) begin
                        d_idx = 0;
                        job_done = 1'b1;
                    end else d_idx++;
                end else stall = 1'b1;
            end else stall = 1'b0;
        end
    end

    task automatic drive_a();
        for (int k = 0; k < qa.size(); k++) begin
            int  w;
            bit  took;
            a_valid = 1'b1; a_data = qa[k].d;
            a_row = qa[k].r[RW-1:0]; a_col = qa[k].c[RW-1:0];
            a_last = (k == qa.size() - 1);
            w = 0; took = 1'b0;
            do begin
                @(negedge clk); took = a_ready;
                @(posedge clk); #1; w++;
            end while (!took && w < 200);
            if (!took) begin fail_now("a_accept"); break; end
            if (k == 0 && chk_clear) chk("ovf_cleared_first_beat", 64'(ovf_flag), 64'd0);
        end
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic drive_b();
        for (int k = 0; k < qb.size(); k++) begin
            int  w;
            bit  took;
            b_valid = 1'b1; b_data = qb[k].d;
            b_row = qb[k].r[RW-1:0]; b_col = qb[k].c[RW-1:0];
            b_last = (k == qb.size() - 1);
            w = 0; took = 1'b0;
            do begin
                @(negedge clk); took = b_ready;
                @(posedge clk); #1; w++;
            end while (!took && w < 200);
            if (!took) begin fail_now("b_accept"); break; end
            if (k == 0 && chk_clear) chk("nan_cleared_first_beat", 64'(nan_flag), 64'd0);
        end
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic run_job(input int mode, input string tag);
        rdy_mode = mode; job_done = 1'b0; comp_cyc = 0; n_beats = 0;
        fork drive_a(); drive_b(); join
        chk_clear = 1'b0;
        for (int k = 0; k < 3000 && !job_done; k++) @(negedge clk);
        if (!job_done) fail_now({tag, "_timeout"});
        chk({tag, "_compute_cycles"}, 64'(comp_cyc), 64'(exp_cyc));
        chk({tag, "_beats"}, 64'(n_beats), 64'(NN));
        @(negedge clk);
        chk({tag, "_c_valid_after"}, 64'(c_valid), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_a_ready_after"}, 64'(a_ready), 64'd1);
        chk({tag, "_ovf"}, 64'(ovf_flag), 64'(exp_ovf));
        chk({tag, "_nan"}, 64'(nan_flag), 64'(exp_nan));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        a_valid = 1'b0; a_data = '0; a_row = '0; a_col = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_row = '0; b_col = '0; b_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_b_ready", 64'(b_ready), 64'd1);
        chk("rst_c_valid", 64'(c_valid), 64'd0);
        chk("rst_c_last", 64'(c_last), 64'd0);
        chk("rst_c_rowcol", 64'({c_row, c_col}), 64'd0);
        chk("rst_c_data", 64'(c_data) & MASK, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({ovf_flag, nan_flag}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 * 1.0 at (0,0)
        qa = '{'{8'h38, 0, 0}}; qb = '{'{8'h38, 0, 0}};
        build_model();
        chk("pin_one_times_one", exp_c[0], 64'd262144);
        run_job(0, "unit");

        // 2*4 + 2*(-2) into C[1][3]
        qa = '{'{8'h40, 1, 2}}; qb = '{'{8'h48, 2, 3}, '{8'hC0, 2, 3}};
        build_model();
        chk("pin_signed_sum", exp_c[1*N+3], 64'd1048576);
        chk("pin_compute_len", 64'(exp_cyc), 64'd4);
        run_job(0, "signed");

        // Smallest subnormals: 2^-9 * 2^-9 = 2^-18
        qa = '{'{8'h01, 0, 0}}; qb = '{'{8'h01, 0, 0}};
        build_model();
        chk("pin_subnormal", exp_c[0], 64'd1);
        run_job(0, "subnormal");

        // NaN operand: product discarded, sticky flag
        qa = '{'{8'h7F, 0, 0}}; qb = '{'{8'h38, 0, 0}};
        build_model();
        chk("pin_nan_zero", exp_c[0], 64'd0);
        run_job(0, "nan");

        // Back-to-back hits on one cell, negative result, fractional operand
        qa = '{'{8'h38, 0, 1}, '{8'h40, 0, 1}, '{8'hB8, 2, 3}, '{8'h48, 7, 0}};
        qb = '{'{8'h38, 1, 2}, '{8'h38, 1, 2}, '{8'h40, 3, 7}, '{8'h30, 0, 0}};
        build_model();
        chk("pin_chain", exp_c[0*N+2], 64'd1572864);
        chk("pin_neg", exp_c[2*N+7], 64'(-64'sd524288));
        chk("pin_half", exp_c[7*N+0], 64'd524288);
        chk_clear = 1'b1;
        run_job(0, "mixed");

        // 33 A beats: the last is dropped, c_ready toggling during drain
        qa.delete();
        for (int k = 0; k < 33; k++) qa.push_back('{8'h38, k % 8, 0});
        qb = '{'{8'h38, 0, 5}};
        build_model();
        chk("pin_ovf_drop", exp_c[5], 64'd1048576);
        run_job(1, "overflow");

        qa = '{'{8'h38, 0, 0}}; qb = '{'{8'h38, 0, 0}};
        build_model();
        chk_clear = 1'b1;
        run_job(0, "after_ovf");

        // Abort a long COMPUTE with reset
        qa.delete(); qb.delete();
        for (int k = 0; k < 5; k++) begin
            qa.push_back('{8'h38, k, 0});
            qb.push_back('{8'h38, 0, k});
        end
        rdy_mode = 0;
        fork drive_a(); drive_b(); join
        seen = 1'b0;
        for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
        if (!busy) fail_now("abort_wait_busy");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_a_ready", 64'(a_ready), 64'd1);
        chk("abort_b_ready", 64'(b_ready), 64'd1);
        chk("abort_c_valid", 64'(c_valid), 64'd0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (c_valid) seen = 1'b1;
        end
        chk("abort_no_output", 64'(seen), 64'd0);
        @(posedge clk); #1;

        qa = '{'{8'h40, 1, 2}}; qb = '{'{8'h48, 2, 3}, '{8'hC0, 2, 3}};
        build_model();
        run_job(1, "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
